// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and depth defaults for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PRIME   = 3'd0,
        ST_RUN     = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_MEMWAIT = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_HALT    = 3'd5
    } pipe_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int DEF_FLUSH_DEPTH = 2;
    localparam int DEF_DRAIN_DEPTH = 3;
    localparam int DEF_CNT_W       = 16;

    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != REG_X0) && (a == b);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       dec_read_reg1;
    logic [4:0]       dec_read_reg2;
    logic             dec_uses_rs1;
    logic             dec_uses_rs2;
    logic             dec_hlt;
    logic             ex_mem_reg;
    logic             ex_reg_write;
    logic [4:0]       ex_write_reg;
    logic             wb_reg_write;
    logic [4:0]       wb_write_reg;
    logic             ex_redirect;
    logic             mem_busy;
    logic             resume;

    logic             pc_write;
    logic             fd_write;
    logic             fd_flush;
    logic             fe_bubble;
    logic             pipe_hold;
    logic             forwardC;
    logic             forwardD;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;

    modport master (
        output dec_read_reg1, dec_read_reg2, dec_uses_rs1, dec_uses_rs2, dec_hlt,
               ex_mem_reg, ex_reg_write, ex_write_reg, wb_reg_write, wb_write_reg,
               ex_redirect, mem_busy, resume,
        input  pc_write, fd_write, fd_flush, fe_bubble, pipe_hold, forwardC, forwardD,
               halted, stall_cycles, flush_cycles
    );

    modport slave (
        input  dec_read_reg1, dec_read_reg2, dec_uses_rs1, dec_uses_rs2, dec_hlt,
               ex_mem_reg, ex_reg_write, ex_write_reg, wb_reg_write, wb_write_reg,
               ex_redirect, mem_busy, resume,
        output pc_write, fd_write, fd_flush, fe_bubble, pipe_hold, forwardC, forwardD,
               halted, stall_cycles, flush_cycles
    );
endinterface

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - combinational load-use and write-back forwarding compares
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_dec_rs1,
    input  logic [4:0] i_dec_rs2,
    input  logic       i_uses_rs1,
    input  logic       i_uses_rs2,
    input  logic       i_ex_mem_reg,
    input  logic       i_ex_reg_write,
    input  logic [4:0] i_ex_rd,
    input  logic       i_wb_reg_write,
    input  logic [4:0] i_wb_rd,
    output logic       o_load_use,
    output logic       o_wb_hit_rs1,
    output logic       o_wb_hit_rs2
);

    logic w_ex_load;
    logic w_rs1_dep;
    logic w_rs2_dep;

    assign w_ex_load = i_ex_mem_reg & i_ex_reg_write;
    // reg_match rejects x0 so it never produces a stall or a forward
    assign w_rs1_dep = i_uses_rs1 & reg_match(i_ex_rd, i_dec_rs1);
    assign w_rs2_dep = i_uses_rs2 & reg_match(i_ex_rd, i_dec_rs2);

    assign o_load_use   = w_ex_load & (w_rs1_dep | w_rs2_dep);
    assign o_wb_hit_rs1 = i_wb_reg_write & reg_match(i_wb_rd, i_dec_rs1);
    assign o_wb_hit_rs2 = i_wb_reg_write & reg_match(i_wb_rd, i_dec_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/bubble sequencer for the 5-stage pipeline
// Optional perf counters built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
    parameter int DRAIN_DEPTH = DEF_DRAIN_DEPTH,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);
    localparam logic [2:0] FLUSH_REST = 3'(FLUSH_DEPTH - 1);
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_DEPTH);

    pipe_state_e r_state;
    pipe_state_e w_nxt_state;
    logic [2:0]  r_cnt;
    logic [2:0]  w_nxt_cnt;

    logic w_load_use;
    logic w_wb_hit_rs1;
    logic w_wb_hit_rs2;

    logic w_pc_write;
    logic w_fd_write;
    logic w_fd_flush;
    logic w_fe_bubble;
    logic w_pipe_hold;
    logic w_halted;
    logic w_fwd_en;

    pipe_hazard_detect u_detect (
        .i_dec_rs1      (bus.dec_read_reg1),
        .i_dec_rs2      (bus.dec_read_reg2),
        .i_uses_rs1     (bus.dec_uses_rs1),
        .i_uses_rs2     (bus.dec_uses_rs2),
        .i_ex_mem_reg   (bus.ex_mem_reg),
        .i_ex_reg_write (bus.ex_reg_write),
        .i_ex_rd        (bus.ex_write_reg),
        .i_wb_reg_write (bus.wb_reg_write),
        .i_wb_rd        (bus.wb_write_reg),
        .o_load_use     (w_load_use),
        .o_wb_hit_rs1   (w_wb_hit_rs1),
        .o_wb_hit_rs2   (w_wb_hit_rs2)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_pc_write  = 1'b1;
        w_fd_write  = 1'b1;
        w_fd_flush  = 1'b0;
        w_fe_bubble = 1'b0;
        w_pipe_hold = 1'b0;
        w_halted    = 1'b0;
        w_fwd_en    = 1'b1;

        case (r_state)
            ST_PRIME: begin
                w_fd_flush  = 1'b1;
                w_fe_bubble = 1'b1;
                w_fwd_en    = 1'b0;
                w_nxt_cnt   = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_nxt_state = ST_RUN;
                end
            end

            // MEMWAIT exit re-evaluates the RUN rules in the same cycle, so both share one arm
            ST_RUN, ST_MEMWAIT: begin
                if (bus.mem_busy) begin
                    w_pipe_hold = 1'b1;
                    w_pc_write  = 1'b0;
                    w_fd_write  = 1'b0;
                    w_nxt_state = ST_MEMWAIT;
                end else if (bus.ex_redirect) begin
                    w_fd_flush  = 1'b1;
                    w_fe_bubble = 1'b1;
                    w_nxt_cnt   = FLUSH_REST;
                    w_nxt_state = (FLUSH_DEPTH == 1) ? ST_RUN : ST_FLUSH;
                end else if (w_load_use) begin
                    w_pc_write  = 1'b0;
                    w_fd_write  = 1'b0;
                    w_fe_bubble = 1'b1;
                    w_nxt_state = ST_RUN;
                end else if (bus.dec_hlt) begin
                    w_pc_write  = 1'b0;
                    w_fd_write  = 1'b0;
                    w_fe_bubble = 1'b1;
                    w_nxt_cnt   = DRAIN_LOAD;
                    w_nxt_state = ST_DRAIN;
                end else begin
                    w_nxt_state = ST_RUN;
                end
            end

            ST_FLUSH: begin
                if (bus.mem_busy) begin
                    w_pipe_hold = 1'b1;
                    w_pc_write  = 1'b0;
                    w_fd_write  = 1'b0;
                end else begin
                    w_fd_flush  = 1'b1;
                    w_fe_bubble = 1'b1;
                    w_nxt_cnt   = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_nxt_state = ST_RUN;
                    end
                end
            end

            ST_DRAIN: begin
                w_pc_write  = 1'b0;
                w_fd_write  = 1'b0;
                w_fe_bubble = 1'b1;
                w_pipe_hold = bus.mem_busy;
                if (!bus.mem_busy) begin
                    w_nxt_cnt = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_nxt_state = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                w_halted    = 1'b1;
                w_pc_write  = 1'b0;
                w_fd_write  = 1'b0;
                w_fe_bubble = 1'b1;
                w_pipe_hold = 1'b1;
                w_fwd_en    = 1'b0;
                if (bus.resume) begin
                    w_nxt_cnt   = FLUSH_LOAD;
                    w_nxt_state = ST_PRIME;
                end
            end

            default: begin
                w_nxt_cnt   = FLUSH_LOAD;
                w_nxt_state = ST_PRIME;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_PRIME;
            r_cnt   <= FLUSH_LOAD;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    assign bus.pc_write  = w_pc_write;
    assign bus.fd_write  = w_fd_write;
    assign bus.fd_flush  = w_fd_flush;
    assign bus.fe_bubble = w_fe_bubble;
    assign bus.pipe_hold = w_pipe_hold;
    assign bus.halted    = w_halted;
    assign bus.forwardC  = w_wb_hit_rs1 & ~w_fe_bubble & w_fwd_en;
    assign bus.forwardD  = w_wb_hit_rs2 & ~w_fe_bubble & w_fwd_en;

`ifdef PIPE_HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_stall_inc;
    logic             w_flush_inc;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_cycles;

    assign w_stall_inc = ~w_pc_write &
                         ((r_state == ST_RUN) || (r_state == ST_MEMWAIT) || (r_state == ST_DRAIN));
    assign w_flush_inc = w_fd_flush & (r_state != ST_PRIME);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
            if (w_flush_inc && (r_flush_cycles != '1)) begin
                r_flush_cycles <= r_flush_cycles + CNT_ONE;
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_cycles = r_flush_cycles;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_cycles = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline.
- Drives stall, flush and bubble controls for the fetch/decode and fetch/execute pipeline registers.
- Generates the decode-stage write-back forwarding selects (forwardC/forwardD).
- Sequences post-reset pipeline priming, branch/jump redirect flushes, data-memory wait stalls and `hlt` drain-then-freeze.

Parameters:
- FLUSH_DEPTH, 2, bubble cycles injected after a redirect or after reset (1..7).
- DRAIN_DEPTH, 3, cycles allowed for in-flight instructions to retire after `hlt` decodes (1..7).
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- dec_read_reg1  in  5  rs1 of instruction in decode
- dec_read_reg2  in  5  rs2 of instruction in decode
- dec_uses_rs1  in  1  decode instruction reads rs1
- dec_uses_rs2  in  1  decode instruction reads rs2
- dec_hlt  in  1  decode instruction is `hlt`
- ex_mem_reg  in  1  execute-stage instruction is a load
- ex_reg_write  in  1  execute-stage instruction writes a register
- ex_write_reg  in  5  execute-stage rd
- wb_reg_write  in  1  write-back stage writes a register
- wb_write_reg  in  5  write-back rd
- ex_redirect  in  1  taken branch, jal or jalr resolved in execute
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- resume  in  1  leave HALT state
- pc_write  out  1  PC update enable
- fd_write  out  1  fetch/decode register enable
- fd_flush  out  1  fetch/decode register loads a NOP
- fe_bubble  out  1  fetch/execute register loads a bubble (all control bits 0, regs 0)
- pipe_hold  out  1  execute/memory/write-back registers hold
- forwardC  out  1  select write-back data for rs1 at fetch/execute register
- forwardD  out  1  select write-back data for rs2 at fetch/execute register
- halted  out  1  processor frozen
- stall_cycles  out  CNT_W  perf counter (see Optional Feature)
- flush_cycles  out  CNT_W  perf counter (see Optional Feature)

Behaviour:
- FSM states: PRIME, RUN, FLUSH, MEMWAIT, DRAIN, HALT. One 3-bit down-counter `cnt` is shared by PRIME, FLUSH and DRAIN.
- Reset: rst_n low at a clk edge sets state=PRIME, cnt=FLUSH_DEPTH, perf counters=0.
- Outputs are combinational from state and inputs; no output registers, so effect is same-cycle.
- Output values while in PRIME (also the reset values):
  - pc_write=1, fd_write=1, fd_flush=1, fe_bubble=1
  - pipe_hold=0, forwardC=0, forwardD=0, halted=0
- PRIME: each cycle `cnt` decrements; at cnt=1 the next state is RUN. PRIME primes the unreset pipeline registers with bubbles.
- RUN, evaluated in priority order (first match wins):
  1. mem_busy → pipe_hold=1, pc_write=0, fd_write=0, fe_bubble=0; next state MEMWAIT.
  2. ex_redirect → fd_flush=1, fe_bubble=1, pc_write=1; cnt=FLUSH_DEPTH-1; next state FLUSH, or RUN if FLUSH_DEPTH=1.
  3. Load-use hazard, defined as ex_mem_reg & ex_reg_write & ex_write_reg!=0 & ((dec_uses_rs1 & rs1==ex_write_reg) | (dec_uses_rs2 & rs2==ex_write_reg)) → pc_write=0, fd_write=0, fe_bubble=1 for exactly that cycle; state stays RUN.
  4. dec_hlt → pc_write=0, fd_write=0, fe_bubble=1; cnt=DRAIN_DEPTH; next state DRAIN.
  5. Otherwise → pc_write=1, fd_write=1, all other controls 0.
- MEMWAIT: outputs as RUN case 1 while mem_busy=1.
  - On mem_busy=0: return to RUN and evaluate RUN rules that same cycle.
  - A redirect asserted during MEMWAIT is honoured on exit; ex_redirect stays asserted because the execute stage is held.
- FLUSH: fd_flush=1, fe_bubble=1, pc_write=1; cnt decrements; at cnt=1 the next state is RUN.
  - mem_busy in FLUSH takes priority: assert pipe_hold and freeze cnt.
  - A new ex_redirect in FLUSH is ignored, since execute holds a bubble.
- DRAIN: pc_write=0, fd_write=0, fe_bubble=1; pipe_hold follows mem_busy; cnt decrements only when mem_busy=0; at cnt=1 the next state is HALT.
- HALT: halted=1, pc_write=0, fd_write=0, fe_bubble=1, pipe_hold=1.
  - resume=1 → state PRIME with cnt=FLUSH_DEPTH; the PC is left pointing at `hlt`+4.
- Forwarding:
  - forwardC = wb_reg_write & wb_write_reg!=0 & wb_write_reg==dec_read_reg1 & !fe_bubble.
  - forwardD is the same expression using dec_read_reg2.
  - Both are forced to 0 in PRIME and HALT.
- Register x0 never causes a hazard or a forward.
- rst_n low in any state, including mid-DRAIN or mid-MEMWAIT, returns the controller to PRIME on the next edge.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_write=0 in RUN, MEMWAIT or DRAIN.
  - flush_cycles increments on every cycle with fd_flush=1 outside PRIME.
  - Both counters saturate at all-ones and clear on reset.
- Not defined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (3-bit encoding)
  - constant REG_X0=5'd0
  - default FLUSH_DEPTH/DRAIN_DEPTH constants shared with the pipeline top
- One sub-module, pipe_hazard_detect: purely combinational load-use and forwarding compare logic, instanced once.

Test Plan:
- Reset with FLUSH_DEPTH=2 → fd_flush=fe_bubble=1 for 2 cycles, then RUN with pc_write=1 and fe_bubble=0.
- `lw x5` in execute with ex_write_reg=5, decode `add x6,x5,x7` (rs1=5, uses_rs1=1) → exactly one cycle of pc_write=0, fd_write=0, fe_bubble=1. The same scenario with ex_write_reg=0 → no stall.
- wb_reg_write=1, wb_write_reg=9, dec_read_reg2=9 → forwardD=1, forwardC=0. With wb_write_reg=0 → both 0.
- ex_redirect pulse in RUN → fd_flush=1 for FLUSH_DEPTH cycles. mem_busy asserted on flush cycle 1 for 3 cycles → pipe_hold=1 for those 3 cycles, and flush completes afterwards.
- mem_busy together with a load-use hazard → pipe_hold=1 and fe_bubble=0 until mem_busy drops, then the single load-use bubble.
- dec_hlt=1 → DRAIN for DRAIN_DEPTH cycles, then halted=1 held for 10 cycles. resume=1 → PRIME bubbles, then RUN. rst_n low mid-DRAIN → PRIME on the next edge.
